// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS MEM-stage load/store sequencer with lane steering,
// alignment exceptions and a bounded wait for the data-memory acknowledge.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall_out,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] DR_out,
  output logic [3:0]  be,
  output logic [5:0]  OP_out,
  output logic        ld_valid,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  output logic [31:0] bad_addr
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d, wd_q, wd_d, dr_q, dr_d, bad_q, bad_d;
  logic [5:0]    op_q, op_d, rop_q, rop_d;
  logic [3:0]    be_q, be_d, rbe_q, rbe_d;
  logic          ldv_q, ldv_d, adel_q, adel_d, ades_q, ades_d, berr_q, berr_d;
  logic          is_mem, is_st, mis, go;
  logic [3:0]    lane;
  logic [31:0]   rep;
  // op[1:0] encodes access size (00 byte, 01 half, 11 word); op[3] marks stores
  always_comb begin
    is_mem = op inside {6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2b, 6'h29, 6'h28};
    is_st  = op[3];
    mis    = (op[1:0] == 2'b01 && addr[0]) || (op[1:0] == 2'b11 && addr[1:0] != 2'b00);
    lane   = op[1:0] == 2'b00 ? 4'b0001 << addr[1:0] : op[1:0] == 2'b01 ? (addr[1] ? 4'hc : 4'h3) : 4'hf;
    rep    = op[1:0] == 2'b00 ? {4{wdata[7:0]}} : op[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    go     = state_q == IDLE && valid_in && is_mem && !mis;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_d    = op_q;
    be_d    = be_q;
    wd_d    = wd_q;
    dr_d    = dr_q;
    rbe_d   = rbe_q;
    rop_d   = rop_q;
    bad_d   = bad_q;
    ldv_d   = 1'b0;
    adel_d  = 1'b0;
    ades_d  = 1'b0;
    berr_d  = 1'b0;
    if (state_q == IDLE) begin
      if (go) begin
        state_d = WAIT;
        cnt_d   = '0;
        addr_d  = addr;
        op_d    = op;
        be_d    = lane;
        wd_d    = rep;
      end else if (valid_in && is_mem) begin
        adel_d = !is_st;
        ades_d = is_st;
        bad_d  = addr;
      end
    end else if (dm_ack) begin
      state_d = IDLE;
      if (!op_q[3]) begin
        dr_d  = dm_rdata;
        rbe_d = be_q;
        rop_d = op_q;
        ldv_d = 1'b1;
      end
    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      berr_d  = 1'b1;
      bad_d   = addr_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_q    <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      dr_q    <= '0;
      rbe_q   <= '0;
      rop_q   <= '0;
      bad_q   <= '0;
      ldv_q   <= 1'b0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      dr_q    <= dr_d;
      rbe_q   <= rbe_d;
      rop_q   <= rop_d;
      bad_q   <= bad_d;
      ldv_q   <= ldv_d;
      adel_q  <= adel_d;
      ades_q  <= ades_d;
      berr_q  <= berr_d;
    end
  end
  assign dm_req    = state_q == WAIT;
  assign dm_we     = dm_req && op_q[3];
  assign dm_addr   = {addr_q[31:2], 2'b00};
  assign dm_be     = be_q;
  assign dm_wdata  = wd_q;
  assign stall_out = go || dm_req;
  assign DR_out    = dr_q;
  assign be        = rbe_q;
  assign OP_out    = rop_q;
  assign ld_valid  = ldv_q;
  assign adel      = adel_q;
  assign ades      = ades_q;
  assign bus_err   = berr_q;
  assign bad_addr  = bad_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store/fault scenarios, checked every cycle
// against a transaction-level model plus hand-computed literal expectations.
module tb_mem_access_unit;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, dm_ack = 1'b0;
  logic [5:0] op = '0;
  logic [31:0] addr = '0, wdata = '0, dm_rdata = '0;
  logic stall_out, dm_req, dm_we, ld_valid, adel, ades, bus_err;
  logic [31:0] dm_addr, dm_wdata, DR_out, bad_addr;
  logic [3:0] dm_be, be;
  logic [5:0] OP_out;
  int total = 0, passed = 0;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .op(op), .addr(addr), .wdata(wdata),
    .stall_out(stall_out), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .DR_out(DR_out), .be(be),
    .OP_out(OP_out), .ld_valid(ld_valid), .adel(adel), .ades(ades), .bus_err(bus_err),
    .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  function automatic bit m_load(input logic [5:0] o);
    return o == 6'h23 || o == 6'h21 || o == 6'h25 || o == 6'h20 || o == 6'h24;
  endfunction
  function automatic bit m_store(input logic [5:0] o);
    return o == 6'h2b || o == 6'h29 || o == 6'h28;
  endfunction
  function automatic int m_size(input logic [5:0] o);
    if (o == 6'h20 || o == 6'h24 || o == 6'h28) return 1;
    if (o == 6'h21 || o == 6'h25 || o == 6'h29) return 2;
    return 4;
  endfunction
  function automatic bit m_mis(input logic [5:0] o, input logic [31:0] a);
    return (a % m_size(o)) != 0;
  endfunction
  function automatic logic [3:0] m_lanes(input logic [5:0] o, input logic [31:0] a);
    logic [3:0] r = '0;
    for (int i = 0; i < m_size(o); i++) r[(a % 4) + i] = 1'b1;
    return r;
  endfunction
  function automatic logic [31:0] m_rep(input logic [5:0] o, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % m_size(o)) +: 8];
    return r;
  endfunction

  // Transaction-level model: one pending access, its WAIT-cycle number, and the
  // most recently reported results.
  bit m_busy, m_ldv, m_adel, m_ades, m_berr;
  int m_cnt;
  logic [31:0] m_addr, m_wd, m_dr, m_bad;
  logic [5:0] m_op, m_rop;
  logic [3:0] m_rbe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_ldv = 0; m_adel = 0; m_ades = 0; m_berr = 0; m_cnt = 0;
      m_addr = 0; m_wd = 0; m_dr = 0; m_bad = 0; m_op = 0; m_rop = 0; m_rbe = 0;
    end else begin
      m_ldv = 0; m_adel = 0; m_ades = 0; m_berr = 0;
      if (!m_busy) begin
        if (valid_in && (m_load(op) || m_store(op))) begin
          if (m_mis(op, addr)) begin
            m_adel = m_load(op); m_ades = m_store(op); m_bad = addr;
          end else begin
            m_busy = 1; m_cnt = 1; m_addr = addr; m_op = op; m_wd = m_rep(op, wdata);
          end
        end
      end else if (dm_ack) begin
        m_busy = 0;
        if (m_load(m_op)) begin
          m_dr = dm_rdata; m_rbe = m_lanes(m_op, m_addr); m_rop = m_op; m_ldv = 1;
        end
      end else if (m_cnt == TIMEOUT) begin
        m_busy = 0; m_berr = 1; m_bad = m_addr;
      end else m_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("stall_out", 32'(stall_out), 32'(m_busy || (valid_in && (m_load(op) || m_store(op)) && !m_mis(op, addr))));
    chk("dm_req", 32'(dm_req), 32'(m_busy));
    chk("dm_we", 32'(dm_we), 32'(m_busy && m_store(m_op)));
    if (m_busy) begin
      chk("dm_addr", dm_addr, m_addr & 32'hffff_fffc);
      chk("dm_be", 32'(dm_be), 32'(m_lanes(m_op, m_addr)));
      chk("dm_wdata", dm_wdata, m_wd);
    end
    chk("ld_valid", 32'(ld_valid), 32'(m_ldv));
    chk("adel", 32'(adel), 32'(m_adel));
    chk("ades", 32'(ades), 32'(m_ades));
    chk("bus_err", 32'(bus_err), 32'(m_berr));
    chk("bad_addr", bad_addr, m_bad);
    chk("DR_out", DR_out, m_dr);
    chk("be", 32'(be), 32'(m_rbe));
    chk("OP_out", 32'(OP_out), 32'(m_rop));
  end

  // Present one access for a cycle, then scramble the inputs to show they are ignored in WAIT.
  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    valid_in = 1'b1; op = o; addr = a; wdata = d;
    @(negedge clk);
    op = 6'h23; addr = 32'hdead_beef; wdata = 32'hffff_ffff;
  endtask
  // Acknowledge on WAIT cycle n (caller is at the negedge of WAIT cycle 1).
  task automatic ack_on(input int n, input logic [31:0] rd);
    repeat (n - 1) @(negedge clk);
    dm_ack = 1'b1; dm_rdata = rd;
    @(negedge clk);
    dm_ack = 1'b0; valid_in = 1'b0;
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst dm_req", 32'(dm_req), 32'd0);
    chk("rst DR_out", DR_out, 32'd0);
    chk("rst bad_addr", bad_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(6'h20, 32'h1003, 32'h0);
    chk("LB dm_be", 32'(dm_be), 32'h8);
    chk("LB dm_addr", dm_addr, 32'h1000);
    chk("LB stall", 32'(stall_out), 32'd1);
    ack_on(3, 32'hAABBCCDD);
    chk("LB ld_valid", 32'(ld_valid), 32'd1);
    chk("LB DR_out", DR_out, 32'hAABBCCDD);
    chk("LB be", 32'(be), 32'h8);
    chk("LB OP_out", 32'(OP_out), 32'h20);
    @(negedge clk);
    chk("LB single pulse", 32'(ld_valid), 32'd0);

    issue(6'h29, 32'h2002, 32'h12345678);
    chk("SH dm_we", 32'(dm_we), 32'd1);
    chk("SH dm_be", 32'(dm_be), 32'hc);
    chk("SH dm_wdata", dm_wdata, 32'h56785678);
    ack_on(1, 32'h0);
    chk("SH no ld_valid", 32'(ld_valid), 32'd0);
    chk("SH DR_out held", DR_out, 32'hAABBCCDD);

    issue(6'h28, 32'h2401, 32'h000000A5);
    chk("SB dm_wdata", dm_wdata, 32'hA5A5A5A5);
    ack_on(2, 32'h0);
    issue(6'h25, 32'h7002, 32'h0);
    ack_on(1, 32'h8765_4321);
    chk("LHU be", 32'(be), 32'hc);

    @(negedge clk);
    valid_in = 1'b1; op = 6'h23; addr = 32'h3001;
    #1 chk("LW mis stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    chk("LW adel", 32'(adel), 32'd1);
    chk("LW bad_addr", bad_addr, 32'h3001);
    op = 6'h29;
    @(negedge clk);
    valid_in = 1'b0;
    chk("SH ades", 32'(ades), 32'd1);
    dm_ack = 1'b1; dm_rdata = 32'h1111_1111;
    @(negedge clk);
    dm_ack = 1'b0;
    @(negedge clk);
    chk("idle ack ignored", 32'(ld_valid), 32'd0);

    issue(6'h23, 32'h4000, 32'h0);
    valid_in = 1'b0;
    w = 0;
    for (int i = 0; i < 40 && !bus_err; i++) begin
      if (dm_req) w++;
      @(negedge clk);
    end
    chk("timeout wait cycles", 32'(w), 32'd16);
    chk("timeout bus_err", 32'(bus_err), 32'd1);
    chk("timeout bad_addr", bad_addr, 32'h4000);
    chk("timeout dm_req", 32'(dm_req), 32'd0);

    issue(6'h23, 32'h5000, 32'h0);
    ack_on(16, 32'h0BAD_F00D);
    chk("late ack ld_valid", 32'(ld_valid), 32'd1);
    chk("late ack bus_err", 32'(bus_err), 32'd0);
    chk("late ack DR_out", DR_out, 32'h0BAD_F00D);

    issue(6'h23, 32'h6000, 32'h0);
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst mid dm_req", 32'(dm_req), 32'd0);
    chk("rst mid DR_out", DR_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; dm_ack = 1'b1; dm_rdata = 32'hCAFE_CAFE;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("rst ack ld_valid", 32'(ld_valid), 32'd0);
    chk("rst ack DR_out", DR_out, 32'd0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
